adder_accum_nbit: RTL
=====================

Name: adder_accum_nbit

Overview:
- Parametrised, registered successor to the team's combinational 8-bit adder.
- Performs ADD, SUB, ACCUMULATE and LOAD operations on WIDTH-bit operands.
- Has a valid/ready handshake on both sides, one-cycle latency, carry and signed-overflow flags, and an internal accumulator register.
- Sits between operand producers and downstream datapath logic that may apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- mode  input  2  operation select: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored in ACC and LOAD).
- clr  input  1  synchronous accumulator clear; sampled every cycle, independent of the handshake.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out; for SUB, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- acc  output  WIDTH  current accumulator value.

Behaviour:
- Reset: clk and rst as above; reset is asynchronous and active-high. Asserting rst at any time, including mid-transfer, immediately clears out_valid, sum, cout, ovf and acc to 0. Any in-flight result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Latency: an input accepted at edge N has its result on sum/cout/ovf, with out_valid=1, after edge N. Back-to-back acceptance gives full throughput when out_ready is held at 1.
- out_valid update on each edge:
  - Set when an input is accepted.
  - Else cleared when the output is consumed.
  - Else held.
- sum/cout/ovf change only on acceptance. They are held stable while out_valid && !out_ready.
- Arithmetic uses a (WIDTH+1)-bit internal sum:
  - ADD: a + b. cout = bit WIDTH.
  - SUB: a + ~b + 1. cout = bit WIDTH.
  - ACC: acc_eff + a, where acc_eff = 0 if clr is asserted that cycle, else acc. On acceptance, acc <= the registered sum value.
  - LOAD: sum = a, cout = 0, ovf = 0. On acceptance, acc <= a.
  - ovf (ADD, ACC): operand MSBs equal and result MSB differs.
  - ovf (SUB): a MSB != b MSB and result MSB != a MSB.
- Wrap-around: results are modulo 2^WIDTH unless SATURATE_EN is defined.
- clr:
  - Without an accepted ACC/LOAD in the same cycle: acc <= 0 on the edge.
  - With an accepted ACC: the accumulate uses 0, so acc <= a.
  - With an accepted LOAD: acc <= a.
  - clr never affects out_valid or the sum/cout/ovf registers.
- acc changes only on accepted ACC/LOAD or on clr. ADD and SUB leave acc untouched.
- in_valid dropped without acceptance: no state change. Producers must hold operands stable until accepted.

Optional Feature:
- Macro: ADDER_ACCUM_SATURATE_EN.
- Defined: on ovf=1, sum (and acc for ACC) is clamped to the signed limit. Positive overflow gives 0111..1; negative overflow gives 1000..0. ovf and cout still report the raw condition.
- Not defined: wrap-around as described in Behaviour; no clamp logic is synthesised.

Test Plan:
- Reset/ADD: hold rst, check all outputs are 0 and in_ready=1. Release, then ADD a=8'h02 b=8'h01 with out_ready=1 → next cycle sum=8'h03, cout=0, ovf=0, out_valid=1, acc=0.
- Carry/overflow: ADD 8'hFF+8'h01 → sum=8'h00, cout=1, ovf=0. ADD 8'h7F+8'h01 → sum=8'h80 (8'h7F with SATURATE_EN), cout=0, ovf=1.
- SUB: 8'h03-8'h05 → sum=8'hFE, cout=0, ovf=0. 8'h80-8'h01 → sum=8'h7F (8'h80 with SATURATE_EN), cout=1, ovf=1.
- Backpressure: accept ADD 1+1, then hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, sum=8'h02 stable, no second acceptance. Raise out_ready → next beat accepted the same cycle.
- Accumulate: LOAD a=8'h10, ACC a=8'h05, ACC a=8'h03 → sums 8'h10/8'h15/8'h18, acc=8'h18. ACC a=8'h07 with clr=1 → sum=8'h07, acc=8'h07. clr alone → acc=0, out_valid unchanged.
- Mid-operation reset: assert rst asynchronously while out_valid=1 and acc=8'h18 → outputs clear immediately without waiting for clk. The first beat after release behaves as from power-up.

Source files
------------

// File: rtl/adder_accum_nbit.sv
// adder_accum_nbit: registered WIDTH-bit ADD/SUB/ACC/LOAD unit with a one-deep output stage,
// carry/overflow flags and an internal accumulator.
//
// Optional feature macro: ADDER_ACCUM_SATURATE_EN clamps overflowing results (and the
// accumulator on ACC) to the signed limits. When undefined, results wrap modulo 2^WIDTH.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  operand beat valid
//   in_ready  block can accept an operand beat (!out_valid || out_ready)
//   mode      00 ADD, 01 SUB, 10 ACC, 11 LOAD
//   a, b      operands (b ignored in ACC and LOAD)
//   clr       synchronous accumulator clear, independent of the handshake
//   out_valid result registers hold an unconsumed result
//   out_ready downstream accepts the result
//   sum       result
//   cout      carry out (SUB: 1 means no borrow)
//   ovf       two's-complement signed overflow
//   acc       current accumulator value
module adder_accum_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {
        ModeAdd  = 2'b00,
        ModeSub  = 2'b01,
        ModeAcc  = 2'b10,
        ModeLoad = 2'b11
    } mode_e;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    mode_e            op;
    logic [WIDTH-1:0] op_a, op_b, acc_eff;
    logic             cin;
    logic [WIDTH:0]   sum_ext;

    assign op       = mode_e'(mode);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign acc_eff  = clr ? '0 : acc_q;

    // ADD, SUB and ACC share one adder; SUB feeds ~b with a carry-in of 1.
    always_comb begin
        op_a = a;
        op_b = b;
        cin  = 1'b0;
        unique case (op)
            ModeAdd:  begin op_a = a;       op_b = b;  cin = 1'b0; end
            ModeSub:  begin op_a = a;       op_b = ~b; cin = 1'b1; end
            ModeAcc:  begin op_a = acc_eff; op_b = a;  cin = 1'b0; end
            ModeLoad: begin op_a = a;       op_b = '0; cin = 1'b0; end
        endcase
    end

    assign sum_ext = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        sum_d  = sum_ext[WIDTH-1:0];
        cout_d = sum_ext[WIDTH];
        // With ~b substituted for b, the SUB overflow rule reduces to the ADD rule.
        ovf_d  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
        if (op == ModeLoad) begin
            sum_d  = a;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end
`ifdef ADDER_ACCUM_SATURATE_EN
        // Overflow direction follows the sign of op_a (operands agree in sign on overflow).
        if (ovf_d) begin
            sum_d = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        acc_d = acc_q;
        if (accept && op == ModeAcc) begin
            acc_d = sum_d;
        end else if (accept && op == ModeLoad) begin
            acc_d = a;
        end else if (clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            acc_q <= acc_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                sum_q       <= sum_d;
                cout_q      <= cout_d;
                ovf_q       <= ovf_d;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign acc       = acc_q;

endmodule
